// File: rtl/dp_mux4_rr_ctl_pkg.sv
// Shared constants and helpers for the 4-way round-robin mux-select controller.
package dp_mux4_rr_ctl_pkg;

  localparam int NREQ = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  // Active-low one-cold select for a given mux input index.
  function automatic logic [NREQ-1:0] park_sel_l(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] idx_of(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dp_mux4_rr_ctl_if.sv
// Requester/downstream bundle between the requesters and the mux-select controller.
interface dp_mux4_rr_ctl_if
  import dp_mux4_rr_ctl_pkg::*;
#(
  parameter int LEN_W = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic                  dst_rdy;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       sel_l;
  logic                  out_vld;
  logic                  out_last;
  logic                  busy;

  modport master (
    output req, req_len, dst_rdy,
    input  gnt, sel_l, out_vld, out_last, busy
  );

  modport slave (
    input  req, req_len, dst_rdy,
    output gnt, sel_l, out_vld, out_last, busy
  );
endinterface

// File: rtl/dp_mux4_rr_ctl_pick.sv
// Rotating-priority picker: first asserted req scanning ptr, ptr+1, ... mod 4.
module dp_rr_pick4
  import dp_mux4_rr_ctl_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   rot_win;
  logic [2*NREQ-1:0] back;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign dbl     = {req, req};
  assign rot     = dbl[{1'b0, ptr} +: NREQ];
  assign rot_win = rot & (~rot + 4'd1);
  assign back    = {rot_win, rot_win} << ptr;
  assign win     = back[2*NREQ-1:NREQ];
  assign any     = |req;
endmodule

// File: rtl/dp_mux4_rr_ctl.sv
// Round-robin burst arbiter owning the one-cold selects of a 4:1 decoded-select mux.
module dp_mux4_rr_ctl
  import dp_mux4_rr_ctl_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int PARK  = 0
)
(
  input  logic             rclk,
  input  logic             arst_l,
  dp_mux4_rr_ctl_if.slave  bus
);
  localparam logic [1:0]      PARK_IDX   = 2'(PARK);
  localparam logic [1:0]      PTR_RST    = PARK_IDX + 2'd1;
  localparam logic [NREQ-1:0] PARK_SEL_L = park_sel_l(PARK_IDX);

  logic [0:0]      state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] sel_l_reg, sel_l_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic            last_reg, last_next;
  logic [1:0]      ptr_reg, ptr_next;

  logic [1:0]      arb_ptr;
  logic [NREQ-1:0] win;
  logic            any;
  logic [LEN_W-1:0] win_len;
  logic            last_beat;
  logic            do_arb;

  // On the closing beat the pointer already points past the current owner.
  assign arb_ptr   = (state_reg == XFER) ? idx_of(gnt_reg) + 2'd1 : ptr_reg;
  assign last_beat = (state_reg == XFER) && bus.dst_rdy && (cnt_reg == '0);
  assign do_arb    = (state_reg == IDLE) || last_beat;
  assign win_len   = bus.req_len[idx_of(win)*LEN_W +: LEN_W];

  dp_rr_pick4 u_pick (
    .req (bus.req),
    .ptr (arb_ptr),
    .win (win),
    .any (any)
  );

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_l_next = sel_l_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    ptr_next   = ptr_reg;

    if (last_beat) ptr_next = arb_ptr;

    if (do_arb && any) begin
      state_next = XFER;
      gnt_next   = win;
      sel_l_next = ~win;
      cnt_next   = win_len;
      last_next  = (win_len == '0);
    end else if (last_beat) begin
      // sel_l deliberately keeps the last grantee so the mux never floats.
      state_next = IDLE;
      gnt_next   = '0;
      last_next  = 1'b0;
    end else if ((state_reg == XFER) && bus.dst_rdy) begin
      cnt_next  = cnt_reg - LEN_W'(1);
      last_next = (cnt_reg == LEN_W'(1));
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      sel_l_reg <= PARK_SEL_L;
      cnt_reg   <= '0;
      last_reg  <= 1'b0;
      ptr_reg   <= PTR_RST;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_l_reg <= sel_l_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.sel_l    = sel_l_reg;
  assign bus.busy     = (state_reg == XFER);
  assign bus.out_vld  = (state_reg == XFER);
  assign bus.out_last = last_reg;

  a_gnt_onehot0: assert property (@(posedge rclk) disable iff (!arst_l) $onehot0(gnt_reg));
  a_sel_onecold: assert property (@(posedge rclk) disable iff (!arst_l) $onehot(~sel_l_reg));
  a_gnt_busy:    assert property (@(posedge rclk) disable iff (!arst_l) ((gnt_reg != '0) == (state_reg == XFER)));
  a_sel_gnt:     assert property (@(posedge rclk) disable iff (!arst_l) ((state_reg == XFER) -> (sel_l_reg == ~gnt_reg)));
endmodule

// File: tb/tb_dp_mux4_rr_ctl.sv
// Scoreboard bench: expected bursts (grantee, beat count) are queued at stimulus and retired on out_last.
module tb_dp_mux4_rr_ctl;
  import dp_mux4_rr_ctl_pkg::*;

  typedef struct {
    int idx;
    int beats;
  } exp_t;

  logic rclk;
  logic arst_l;
  int   n_cmp;
  int   n_err;
  int   beat_cnt;
  exp_t q[$];

  dp_mux4_rr_ctl_if #(.LEN_W(4)) bus ();

  dp_mux4_rr_ctl #(.LEN_W(4), .PARK(0)) dut (
    .rclk   (rclk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input int idx, input int beats);
    exp_t e;
    e.idx   = idx;
    e.beats = beats;
    q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy; i++) step();
    chk("idle_reached", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},   {28'd0, bus.gnt},   32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy},  32'd0);
    chk({tag, "_vld"},   {31'd0, bus.out_vld}, 32'd0);
    chk({tag, "_last"},  {31'd0, bus.out_last}, 32'd0);
    chk({tag, "_sel_l"}, {28'd0, bus.sel_l}, 32'h0000_000E);
  endtask

  // Beat monitor: one line per retired burst.
  always @(negedge rclk) begin
    exp_t e;
    if (!arst_l) begin
      beat_cnt = 0;
    end else begin
      chk("out_vld_eq_busy", {31'd0, bus.out_vld}, {31'd0, bus.busy});
      if (bus.busy && bus.dst_rdy) begin
        chk("sel_vs_gnt", {28'd0, bus.sel_l}, {28'd0, ~bus.gnt});
        if (q.size() == 0) begin
          chk("unexpected_beat", {31'd0, bus.busy}, 32'd0);
        end else begin
          beat_cnt++;
          chk("out_last", {31'd0, bus.out_last}, {31'd0, (beat_cnt == q[0].beats)});
          if (bus.out_last) begin
            e = q.pop_front();
            chk("grantee", {28'd0, bus.gnt}, 32'd1 << e.idx);
            chk("beats", beat_cnt, e.beats);
            $display("burst: req %0d beats %0d (exp req %0d beats %0d)",
                     idx_of(bus.gnt), beat_cnt, e.idx, e.beats);
            beat_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_gnt;
    logic       rdy_pat [5];
    logic       last_pat[5];

    n_cmp = 0;
    n_err = 0;
    beat_cnt = 0;
    arst_l = 1'b0;
    bus.req = '0;
    bus.req_len = '0;
    bus.dst_rdy = 1'b0;

    // Reset held with random inputs.
    repeat (3) begin
      step();
      bus.req     = 4'($urandom);
      bus.req_len = 16'($urandom);
      bus.dst_rdy = 1'($urandom);
    end
    chk_reset_vals("rst_hold");
    bus.req = '0;
    bus.req_len = '0;
    bus.dst_rdy = 1'b0;
    step();
    arst_l = 1'b1;

    // Single requester 2, 4 beats; sel_l held afterwards.
    step();
    bus.req = 4'b0100;
    bus.req_len = 16'h0300;
    bus.dst_rdy = 1'b1;
    push(2, 4);
    step();
    chk("single_gnt", {28'd0, bus.gnt}, 32'h4);
    chk("single_sel_l", {28'd0, bus.sel_l}, 32'hB);
    bus.req = '0;
    wait_idle(20);
    chk("single_idle_sel_l", {28'd0, bus.sel_l}, 32'hB);
    chk("single_idle_gnt", {28'd0, bus.gnt}, 32'h0);

    // Short reset pulse away from any edge so the pointer restarts at 1.
    arst_l = 1'b0;
    #2;
    arst_l = 1'b1;

    // Fairness: all four requesting, single-beat bursts back-to-back.
    step();
    bus.req = 4'b1111;
    bus.req_len = '0;
    bus.dst_rdy = 1'b1;
    for (int k = 0; k < 8; k++) push((k + 1) % 4, 1);
    for (int k = 0; k < 8; k++) begin
      step();
      exp_gnt = 4'b0001 << ((k + 1) % 4);
      chk("fair_busy", {31'd0, bus.busy}, 32'd1);
      chk("fair_gnt", {28'd0, bus.gnt}, {28'd0, exp_gnt});
    end
    bus.req = '0;
    wait_idle(10);

    // Backpressure: 3-beat burst on requester 0 with dst_rdy 1,0,0,1,1.
    rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    last_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.req = 4'b0001;
    bus.req_len = 16'h0002;
    bus.dst_rdy = 1'b1;
    push(0, 3);
    step();
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      bus.dst_rdy = rdy_pat[i];
      chk("bp_last", {31'd0, bus.out_last}, {31'd0, last_pat[i]});
      chk("bp_gnt", {28'd0, bus.gnt}, 32'h1);
      step();
    end
    chk("bp_done", {31'd0, bus.busy}, 32'd0);
    bus.dst_rdy = 1'b1;

    // Requester 1 drops req on beat 2; burst still runs 8 beats, then requester 3.
    bus.req = 4'b1011;
    bus.req_len = 16'h0070;
    push(1, 8);
    push(3, 1);
    step();
    chk("drop_gnt1", {28'd0, bus.gnt}, 32'h2);
    step();
    bus.req = 4'b1001;
    repeat (7) step();
    chk("drop_next_gnt", {28'd0, bus.gnt}, 32'h8);
    bus.req = '0;
    wait_idle(10);

    // Maximum length: 16 beats from a 4'hF length field.
    bus.req = 4'b0001;
    bus.req_len = 16'h000F;
    push(0, 16);
    step();
    bus.req = '0;
    wait_idle(30);

    // Reset mid-burst takes effect without a clock edge.
    bus.req = 4'b0100;
    bus.req_len = 16'h0F00;
    push(2, 16);
    repeat (4) step();
    bus.req = '0;
    chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
    #2;
    arst_l = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    q.delete();
    step();
    arst_l = 1'b1;
    repeat (3) step();
    chk_reset_vals("post_rst");

    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
